// File: rtl/memory_pkg.sv
// Shared definitions for the memory block and its requester-side load/store unit.
// Provides the LSU state encoding, access-size codes, the latched request payload,
// default read latency / RAM decode bit, and the fault-classification helper.
package memory_pkg;

  localparam int unsigned DATA_W                 = 32;
  localparam int unsigned ADDR_W                 = 32;
  localparam int unsigned DEFAULT_READ_LATENCY   = 2;
  localparam int unsigned DEFAULT_RAM_SELECT_BIT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } lsu_size_t;

  // Request fields kept for the lifetime of one access.
  typedef struct packed {
    logic              write;
    lsu_size_t         size;
    logic              isUnsigned;
    logic [1:0]        byteOffset;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Misaligned access, illegal size, or a store aimed at ROM.
  function automatic logic lsuFault(input logic isWrite, input lsu_size_t size,
                                    input logic [1:0] lowAddr, input logic ramSel);
    logic misaligned;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lowAddr[0];
      SIZE_WORD: misaligned = (lowAddr != 2'b00);
      default:   misaligned = 1'b1;
    endcase
    return misaligned || (isWrite && !ramSel);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bus of the load/store unit.
// master: pipeline (drives req_*, receives req_ready and resp_*)
// slave : load_store_unit
interface load_store_unit_if;
  import memory_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_error;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic shared by the load and store paths.
// Ports:
//   word         in  memory word as read back
//   byteOffset   in  addr[1:0] of the access
//   size         in  access size
//   isUnsigned   in  zero-extend (1) / sign-extend (0) loads
//   storeData    in  right-aligned store data
//   loadData_c   out extracted and extended load value
//   mergedWord_c out word with the addressed bytes replaced by storeData
module lsu_byte_lane
  import memory_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        byteOffset,
  input  lsu_size_t         size,
  input  logic              isUnsigned,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadData_c,
  output logic [DATA_W-1:0] mergedWord_c
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Little-endian lane select, then extend or merge by size.
  always_comb begin
    byteSel      = 8'h00;
    halfSel      = byteOffset[1] ? word[31:16] : word[15:0];
    loadData_c   = word;
    mergedWord_c = word;

    case (byteOffset)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase

    case (size)
      SIZE_BYTE: begin
        loadData_c = isUnsigned ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
        case (byteOffset)
          2'd0:    mergedWord_c[7:0]   = storeData[7:0];
          2'd1:    mergedWord_c[15:8]  = storeData[7:0];
          2'd2:    mergedWord_c[23:16] = storeData[7:0];
          default: mergedWord_c[31:24] = storeData[7:0];
        endcase
      end
      SIZE_HALF: begin
        loadData_c = isUnsigned ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
        if (byteOffset[1]) mergedWord_c[31:16] = storeData[15:0];
        else               mergedWord_c[15:0]  = storeData[15:0];
      end
      default: begin
        loadData_c   = word;
        mergedWord_c = storeData;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Requester-side load/store port into the unified ROM/RAM block. Converts one
// load/store per handshake into word-aligned memory cycles, uses read-modify-write
// for sub-word stores, and reports misaligned accesses / ROM stores as faults
// without touching memory.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   bus            request/response handshake (load_store_unit_if.slave)
//   mem_address    word-aligned memory address (registered)
//   mem_readWrite  1 = write cycle (registered, high only in WRITE)
//   mem_dataIn     word to write (registered)
//   mem_dataOut    word read, valid READ_LATENCY edges after the address
module load_store_unit
  import memory_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = DEFAULT_READ_LATENCY,
  parameter int unsigned RAM_SELECT_BIT = DEFAULT_RAM_SELECT_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_readWrite,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  localparam int unsigned CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  lsu_state_t        state;
  logic [CNT_W-1:0]  latCnt;
  lsu_req_t          req;
  logic              reqFault_c;
  logic [DATA_W-1:0] laneLoad_c;
  logic [DATA_W-1:0] laneMerge_c;

  always_comb begin
    reqFault_c = lsuFault(bus.req_write, lsu_size_t'(bus.req_size), bus.req_addr[1:0],
                          bus.req_addr[RAM_SELECT_BIT]);
  end

  // Lane logic looks at the live read data so the capture edge can use it directly.
  lsu_byte_lane uLane (
    .word         (mem_dataOut),
    .byteOffset   (req.byteOffset),
    .size         (req.size),
    .isUnsigned   (req.isUnsigned),
    .storeData    (req.wdata),
    .loadData_c   (laneLoad_c),
    .mergedWord_c (laneMerge_c)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      latCnt         <= '0;
      req            <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= '0;
      mem_address    <= '0;
      mem_readWrite  <= 1'b0;
      mem_dataIn     <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      mem_readWrite  <= 1'b0;

      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            req <= '{write:      bus.req_write,
                     size:       lsu_size_t'(bus.req_size),
                     isUnsigned: bus.req_unsigned,
                     byteOffset: bus.req_addr[1:0],
                     wdata:      bus.req_wdata};
            if (reqFault_c) begin
              // Faults skip memory entirely; mem_address keeps its old value.
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_write && (lsu_size_t'(bus.req_size) == SIZE_WORD)) begin
              state         <= WRITE;
              mem_address   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_readWrite <= 1'b1;
              mem_dataIn    <= bus.req_wdata;
            end else begin
              state       <= READ;
              mem_address <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              latCnt      <= CNT_W'(READ_LATENCY);
            end
          end
        end

        READ: begin
          // Counter at zero means mem_dataOut now holds the addressed word.
          if (latCnt == '0) begin
            if (req.write) begin
              state         <= WRITE;
              mem_readWrite <= 1'b1;
              mem_dataIn    <= laneMerge_c;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b0;
              bus.resp_rdata <= laneLoad_c;
            end
          end else begin
            latCnt <= latCnt - CNT_W'(1);
          end
        end

        WRITE: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_error <= 1'b0;
          bus.resp_rdata <= '0;
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
